// File: rtl/seq_scan_ctrl.sv
// Serial pattern scan controller: programmable PAT_W-bit pattern, overlapping or
// non-overlapping detection, session ends on target match count, bit timeout or abort.
module seq_scan_ctrl #(
  parameter int                PAT_W   = 4,
  parameter int                CNT_W   = 8,
  parameter logic [PAT_W-1:0]  PAT_RST = 4'b1001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             timed_out,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             state, state_nx;
  logic               busy_nx, done_nx, hit_nx, timed_out_nx;
  logic [CNT_W-1:0]   match_count_nx, bit_count_nx;
  logic [PAT_W-2:0]   shift, shift_nx;
  logic [FILL_W-1:0]  fill, fill_nx;
  logic [PAT_W-1:0]   pattern, pattern_nx;
  logic               overlap, overlap_nx;
  logic [CNT_W-1:0]   target, target_nx;
  logic [CNT_W-1:0]   timeout, timeout_nx;

  logic [PAT_W-1:0]   window;
  logic [CNT_W:0]     mc_inc, bc_inc;
  logic               accept, reach_target, reach_timeout;

  // Window as it would look with the presented bit shifted in; a match needs a full window.
  assign window        = {shift, din};
  assign accept        = (state == S_SCAN) && din_valid && !abort;
  assign match_pulse   = accept && (fill == FILL_MAX) && (window == pattern);
  assign mc_inc        = {1'b0, match_count} + 1'b1;
  assign bc_inc        = {1'b0, bit_count} + 1'b1;
  assign reach_target  = (mc_inc == {1'b0, target});
  assign reach_timeout = (timeout != '0) && (bc_inc == {1'b0, timeout});

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_nx       = state;
    hit_nx         = hit;
    timed_out_nx   = timed_out;
    match_count_nx = match_count;
    bit_count_nx   = bit_count;
    shift_nx       = shift;
    fill_nx        = fill;
    pattern_nx     = pattern;
    overlap_nx     = overlap;
    target_nx      = target;
    timeout_nx     = timeout;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (cfg_we) begin
          pattern_nx = cfg_pattern;
          overlap_nx = cfg_overlap;
          target_nx  = cfg_target;
          timeout_nx = cfg_timeout;
        end
        if (start && !abort) begin
          match_count_nx = '0;
          bit_count_nx   = '0;
          shift_nx       = '0;
          fill_nx        = '0;
          timed_out_nx   = 1'b0;
          // A zero target is met before any bit arrives.
          if (target_nx == '0) begin
            hit_nx   = 1'b1;
            state_nx = S_DONE;
          end else begin
            hit_nx   = 1'b0;
            state_nx = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (din_valid) begin
          shift_nx     = window[PAT_W-2:0];
          bit_count_nx = bc_inc[CNT_W] ? CNT_MAX : bc_inc[CNT_W-1:0];
          if (match_pulse) begin
            match_count_nx = mc_inc[CNT_W] ? CNT_MAX : mc_inc[CNT_W-1:0];
            fill_nx        = overlap ? fill : '0;
          end else if (fill != FILL_MAX) begin
            fill_nx = fill + 1'b1;
          end
          // Target takes priority when both conditions land on the same bit.
          if (match_pulse && reach_target) begin
            hit_nx   = 1'b1;
            state_nx = S_DONE;
          end else if (reach_timeout) begin
            timed_out_nx = 1'b1;
            state_nx     = S_DONE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    busy_nx = (state_nx == S_SCAN);
    done_nx = (state_nx == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      timed_out   <= 1'b0;
      match_count <= '0;
      bit_count   <= '0;
      shift       <= '0;
      fill        <= '0;
      pattern     <= PAT_RST;
      overlap     <= 1'b0;
      target      <= CNT_W'(1);
      timeout     <= '0;
    end else begin
      state       <= state_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      hit         <= hit_nx;
      timed_out   <= timed_out_nx;
      match_count <= match_count_nx;
      bit_count   <= bit_count_nx;
      shift       <= shift_nx;
      fill        <= fill_nx;
      pattern     <= pattern_nx;
      overlap     <= overlap_nx;
      target      <= target_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller for the team's serial pattern detector path.
- Holds a programmable PAT_W-bit pattern and a mode bit (overlapping / non-overlapping), and runs a scan session over a qualified serial bit stream.
- Each match produces a same-cycle Mealy pulse and is counted. The session ends on reaching a target match count, on a bit-count timeout, or on abort.
- Sits between the config/host logic and the serial input.

Parameters:
- PAT_W, 4, pattern length in bits (≥2).
- CNT_W, 8, width of match counter, target, bit counter and timeout.
- PAT_RST, 4'b1001, pattern value loaded at reset (PAT_W bits).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe; honoured only in IDLE or DONE.
- cfg_pattern  in  PAT_W  pattern; MSB is the first bit received.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNT_W  match count that ends the session.
- cfg_timeout  in  CNT_W  max valid bits per session; 0 = disabled.
- start  in  1  begin session (from IDLE or DONE).
- abort  in  1  terminate session, go to IDLE.
- din_valid  in  1  qualifies din.
- din  in  1  serial data bit.
- busy  out  1  high in SCAN.
- done  out  1  high in DONE.
- hit  out  1  valid in DONE: target reached.
- timed_out  out  1  valid in DONE: timeout reached without hit.
- match_pulse  out  1  combinational; high in the cycle the completing bit is presented.
- match_count  out  CNT_W  matches this session.
- bit_count  out  CNT_W  valid bits consumed this session.

Behaviour:
- Reset (sync, dominates all inputs): state=IDLE; busy/done/hit/timed_out=0; match_count=0; bit_count=0; shift=0; fill=0; pattern=PAT_RST; target=1; timeout=0; overlap=0.
- FSM states: IDLE, SCAN, DONE. All outputs except match_pulse are registered.
- Config:
  - cfg_we in IDLE/DONE latches pattern, overlap, target and timeout at the clock edge.
  - cfg_we in SCAN is ignored.
  - cfg_we together with start uses the new config for that session.
- IDLE/DONE → SCAN on start (abort low):
  - clears match_count, bit_count, shift, fill, hit and timed_out.
  - busy=1 and done=0 from the next cycle.
- Start with target==0: goes directly to DONE with hit=1, counts 0.
- SCAN, bit acceptance: a bit is accepted when din_valid=1.
  - shift <= {shift[PAT_W-2:0], din}.
  - bit_count += 1.
  - fill = number of bits in the current window, saturating at PAT_W-1 once the match condition is reachable.
- SCAN, match detection:
  - Match iff din_valid && fill ≥ PAT_W-1 && {shift[PAT_W-2:0], din} == pattern.
  - match_pulse = that condition, combinational, only in SCAN.
- SCAN, on a match:
  - match_count += 1.
  - Non-overlap: fill <= 0 and the window restarts empty.
  - Overlap: fill is unchanged.
- SCAN → DONE:
  - If match_count+1 == target on a matching bit: hit=1.
  - Else if timeout≠0 and bit_count+1 == timeout on any accepted bit: timed_out=1.
  - Hit and timeout on the same bit: hit=1, timed_out=0.
  - The bit that ends the session is counted; later bits are ignored.
- SCAN → IDLE on abort:
  - busy=0, done stays 0, counters hold their values.
  - An accepted bit in the abort cycle is dropped (no count, no pulse).
  - abort and start together: abort wins. abort outside SCAN is a no-op.
- DONE:
  - Holds hit, timed_out and counters until start or reset.
  - match_pulse=0; din ignored.
- Counters do not wrap within a session: termination conditions fire first when timeout≠0. With timeout=0 and an unreachable target, match_count and bit_count saturate at 2^CNT_W-1.
- din_valid=0 cycles: no state change in the shift/fill/count path.

Test Plan:
- Reset; pattern=1001, overlap=0, target=5, timeout=0; start; stream 1,0,0,1,0,0,1 → match_pulse only on the 4th bit; match_count=1; bit_count=7; busy=1.
- Same stream with overlap=1 → match_pulse on the 4th and 7th bits; match_count=2.
- target=2, overlap=1, stream 1001001 → DONE one cycle after the 7th bit; hit=1, timed_out=0, match_count=2; an 8th bit leaves bit_count=7.
- timeout=6, target=3, stream 100100 with overlap=0 → DONE after the 6th bit; timed_out=1, hit=0, match_count=1. Then target=2, timeout=7, overlap=1, stream 1001001 → hit=1, timed_out=0 (hit priority).
- Mid-session abort with din_valid=1 → IDLE; bit dropped; done=0. cfg_we during SCAN with pattern=0110 → pattern unchanged (next session still detects 1001). start+abort in SCAN → IDLE.
- Reset asserted mid-SCAN → all outputs 0 next cycle; pattern returns to 1001. Start with target=0 → done=1, hit=1 next cycle.
